// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stall/flush/redirect controls between pipeline and hazard controller
interface pipeline_hazard_ctrl_if;
  logic        mem_read_id_ex;
  logic [4:0]  rd_id_ex;
  logic [4:0]  rs1_if_id;
  logic [4:0]  rs2_if_id;
  logic        rs1_used;
  logic        rs2_used;
  logic        branch_ex_mem;
  logic        zero_ex_mem;
  logic        predict_taken_ex_mem;
  logic [31:0] pc_branch_ex_mem;
  logic [31:0] pc_4_ex_mem;
  logic        dmem_req;
  logic        dmem_ready;
  logic        stall_pc;
  logic        stall_if_id;
  logic        stall_id_ex;
  logic        stall_ex_mem;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bus_err;
  logic [31:0] perf_mispredict;
  logic [31:0] perf_loaduse;
  logic [31:0] perf_memwait;

  modport master (
    output mem_read_id_ex, rd_id_ex, rs1_if_id, rs2_if_id, rs1_used, rs2_used,
           branch_ex_mem, zero_ex_mem, predict_taken_ex_mem, pc_branch_ex_mem,
           pc_4_ex_mem, dmem_req, dmem_ready,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_ex_mem, redirect_valid, redirect_pc, bus_err,
           perf_mispredict, perf_loaduse, perf_memwait
  );

  modport slave (
    input  mem_read_id_ex, rd_id_ex, rs1_if_id, rs2_if_id, rs1_used, rs2_used,
           branch_ex_mem, zero_ex_mem, predict_taken_ex_mem, pc_branch_ex_mem,
           pc_4_ex_mem, dmem_req, dmem_ready,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_ex_mem, redirect_valid, redirect_pc, bus_err,
           perf_mispredict, perf_loaduse, perf_memwait
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - branch redirect, load-use stall and memory-wait freeze for the 5-stage pipeline
// Optional event counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        actual_taken;
  logic        mispredict;
  logic        load_use;
  logic        stall_all;
  logic        ld_stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  always_comb begin
    actual_taken = hz.branch_ex_mem & hz.zero_ex_mem;
    mispredict   = actual_taken ^ hz.predict_taken_ex_mem;
    load_use     = hz.mem_read_id_ex & (hz.rd_id_ex != 5'd0) &
                   ((hz.rs1_used & (hz.rs1_if_id == hz.rd_id_ex)) |
                    (hz.rs2_used & (hz.rs2_if_id == hz.rd_id_ex)));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    stall_all = 1'b0;
    ld_stall  = 1'b0;
    redirect  = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.dmem_req & ~hz.dmem_ready) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = 8'd1;
        end else if (mispredict) begin
          redirect = 1'b1;
        end else if (load_use) begin
          ld_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Hazards are masked here; the branch is held in MEM and acts once RUN resumes.
        if (hz.dmem_ready) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          stall_all = 1'b1;
          if (cnt_q >= WAIT_MAX_C) begin
            state_d   = ERROR;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ERROR: begin
        stall_all = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    redirect_pc = 32'd0;
    if (redirect) begin
      redirect_pc = actual_taken ? hz.pc_branch_ex_mem : hz.pc_4_ex_mem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign hz.stall_pc       = stall_all | ld_stall;
  assign hz.stall_if_id    = stall_all | ld_stall;
  assign hz.stall_id_ex    = stall_all;
  assign hz.stall_ex_mem   = stall_all;
  assign hz.flush_if_id    = redirect;
  assign hz.flush_id_ex    = redirect | ld_stall;
  assign hz.flush_ex_mem   = redirect;
  assign hz.redirect_valid = redirect;
  assign hz.redirect_pc    = redirect_pc;
  assign hz.bus_err        = bus_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_mis_q, perf_mis_d;
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_mw_q, perf_mw_d;

  always_comb begin
    perf_mis_d = perf_mis_q + {31'd0, redirect};
    perf_lu_d  = perf_lu_q + {31'd0, ld_stall};
    perf_mw_d  = perf_mw_q + {31'd0, (state_q == MEM_WAIT)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mis_q <= 32'd0;
      perf_lu_q  <= 32'd0;
      perf_mw_q  <= 32'd0;
    end else begin
      perf_mis_q <= perf_mis_d;
      perf_lu_q  <= perf_lu_d;
      perf_mw_q  <= perf_mw_d;
    end
  end

  assign hz.perf_mispredict = perf_mis_q;
  assign hz.perf_loaduse    = perf_lu_q;
  assign hz.perf_memwait    = perf_mw_q;
`else
  assign hz.perf_mispredict = 32'd0;
  assign hz.perf_loaduse    = 32'd0;
  assign hz.perf_memwait    = 32'd0;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. It detects branch mispredictions when the branch reaches MEM and drives the redirect PC. It also detects load-use hazards between ID and EX, and freezes the whole pipeline while data memory is busy. It generates the stall/flush controls consumed by the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. A flush input to a pipeline register zeroes that register on the next clock edge.

## Interface
Parameters:
- WAIT_MAX, 16 — maximum consecutive memory-wait cycles before a bus error is declared (legal range 2..255).

Ports:
- clk  in  1  — single clock; all state updates on posedge.
- rst  in  1  — asynchronous, active-high reset.
- mem_read_id_ex  in  1  — the instruction in EX is a load.
- rd_id_ex  in  5  — destination register of the instruction in EX.
- rs1_if_id, rs2_if_id  in  5 each  — source registers of the instruction in ID.
- rs1_used, rs2_used  in  1 each  — the ID instruction actually reads rs1 / rs2.
- branch_ex_mem  in  1  — the instruction in MEM is a conditional branch.
- zero_ex_mem  in  1  — branch condition result at MEM.
- predict_taken_ex_mem  in  1  — the prediction made in ID, carried to MEM.
- pc_branch_ex_mem  in  32  — branch target.
- pc_4_ex_mem  in  32  — fall-through PC (PC+4).
- dmem_req  in  1  — MEM-stage load or store is active.
- dmem_ready  in  1  — data memory completes the access this cycle.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  — hold the register.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  — zero the register.
- redirect_valid  out  1  — load redirect_pc into the PC.
- redirect_pc  out  32  — corrected fetch address.
- bus_err  out  1  — sticky memory-timeout error.
- perf_mispredict, perf_loaduse, perf_memwait  out  32 each  — event counters.

## Operation
- State machine: RUN, MEM_WAIT, ERROR. The wait counter is 8 bits wide.
- **actual_taken** = branch_ex_mem & zero_ex_mem.
- **mispredict** = actual_taken XOR predict_taken_ex_mem. A non-branch that was predicted taken therefore redirects to pc_4.
- **redirect_pc** = actual_taken ? pc_branch_ex_mem : pc_4_ex_mem. It is driven as 0 when redirect_valid is 0.
- **load_use** = mem_read_id_ex & (rd_id_ex≠0) & ((rs1_used & rs1_if_id==rd_id_ex) | (rs2_used & rs2_if_id==rd_id_ex)).
- Behaviour in RUN, in priority order:
  1. dmem_req & !dmem_ready: assert all four stall_* outputs, with no flush and no redirect. Next state is MEM_WAIT and the counter is set to 1.
  2. mispredict: assert redirect_valid and flush_if_id, flush_id_ex, flush_ex_mem. The load_use result is ignored. Remain in RUN.
  3. load_use: assert stall_pc and stall_if_id, and assert flush_id_ex to insert a bubble.
  4. Otherwise: all controls are 0.
- MEM_WAIT:
  - All four stalls are asserted. Mispredict and load_use are masked.
  - The counter increments each cycle while dmem_ready is 0.
  - dmem_ready=1: stalls drop the same cycle and the next state is RUN.
  - Counter reaches WAIT_MAX with dmem_ready still 0: the next state is ERROR.
- ERROR: all stalls are asserted and bus_err=1. The state is left only by rst.
- dmem_ready=1 in the same cycle as dmem_req: no wait state is entered.

## Timing
- All stall, flush and redirect outputs are combinational from the inputs and the current state, so they act at the next clk edge.
- Redirect latency: a mispredicting branch in MEM at cycle N causes the PC to fetch redirect_pc at N+1. Younger instructions in three stages are squashed.
- A load-use stall lasts exactly 1 cycle, because the load advances to MEM and the hazard clears.
- bus_err rises on the edge at which the counter would exceed WAIT_MAX. That is WAIT_MAX cycles after MEM_WAIT is entered.
- Reset values:
  - State RUN, counter 0, bus_err 0, and all perf counters 0.
  - With idle inputs, every output is 0.
- rst asserted mid-wait or in ERROR returns the block to RUN asynchronously.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - perf_mispredict increments on each cycle with redirect_valid=1.
  - perf_loaduse increments on each load-use stall cycle.
  - perf_memwait increments on each cycle in MEM_WAIT.
  - All three counters wrap at 2^32.
- PIPE_HAZARD_PERF_EN undefined: the counter registers are not built, and all three perf outputs are constant 0.

## Test plan
- Branch at MEM with branch=1, zero=1, predict=0, target 0x0000_0100 -> redirect_valid=1, redirect_pc=0x100, all three flush outputs=1 for one cycle.
- Non-branch with predict=1 and pc_4=0x0000_0044 -> redirect_pc=0x44. With branch=1, zero=0, predict=0 -> no redirect.
- Load in EX with rd=5 and ID rs2=5, rs2_used=1 -> stall_pc=stall_if_id=flush_id_ex=1 for exactly 1 cycle. With rd=0 -> no stall.
- dmem_req=1 and dmem_ready=0 for 3 cycles, then 1 -> all stalls held 3 cycles, then return to RUN. perf_memwait=3 when PIPE_HAZARD_PERF_EN is defined, 0 when undefined.
- dmem_ready held 0 with WAIT_MAX=4 -> bus_err=1 after 4 cycles and stays 1. Pulsing rst clears it to 0.
- Mispredict and load_use in the same cycle -> only the flushes and redirect are asserted, with no stall_pc. Mispredict during MEM_WAIT -> ignored until the wait ends.
